// File: rtl/qlearn_pkg.sv
// Shared types and constants for the Q-learning episode sequencer.
package qlearn_pkg;

    localparam int unsigned STATE_W    = 4;
    localparam int unsigned ACT_W      = 2;
    localparam int unsigned NUM_STATES = 15;
    localparam logic [STATE_W-1:0] SEL_NONE = STATE_W'(0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACT   = 3'd1,
        ST_RDQ   = 3'd2,
        ST_RDMAX = 3'd3,
        ST_CALC  = 3'd4,
        ST_WR    = 3'd5,
        ST_DONE  = 3'd6
    } ctrl_state_e;

    typedef enum logic [ACT_W-1:0] {
        ACT_UP    = 2'd0,
        ACT_RIGHT = 2'd1,
        ACT_DOWN  = 2'd2,
        ACT_LEFT  = 2'd3
    } action_e;

endpackage

// File: rtl/qlearn_step_ctrl_if.sv
// Policy, environment and Q-bank signals of the episode sequencer; master = sequencer.
interface qlearn_step_ctrl_if
    import qlearn_pkg::*;
#(
    parameter int unsigned Q_W = 16,
    parameter int unsigned R_W = 8
);
    logic                      start;
    logic                      abort;
    logic                      act_req;
    logic                      act_ack;
    logic [ACT_W-1:0]          act_dir;
    logic [STATE_W-1:0]        env_next;
    logic signed [R_W-1:0]     env_reward;
    logic [STATE_W-1:0]        at;
    logic [ACT_W-1:0]          q_act;
    logic signed [Q_W-1:0]     q_rd_data;
    logic signed [Q_W-1:0]     q_max_data;
    logic                      q_we;
    logic signed [Q_W-1:0]     q_wdata;
    logic [STATE_W-1:0]        cur_state;
    logic [7:0]                steps;
    logic                      busy;
    logic                      done;
    logic                      goal_reached;

    modport master (
        input  start, abort, act_ack, act_dir, env_next, env_reward, q_rd_data, q_max_data,
        output act_req, at, q_act, q_we, q_wdata, cur_state, steps, busy, done, goal_reached
    );

    modport slave (
        output start, abort, act_ack, act_dir, env_next, env_reward, q_rd_data, q_max_data,
        input  act_req, at, q_act, q_we, q_wdata, cur_state, steps, busy, done, goal_reached
    );
endinterface

// File: rtl/qlearn_td_calc.sv
// Combinational temporal-difference update; QCTRL_SAT_EN selects saturation instead of wrap.
module qlearn_td_calc
    import qlearn_pkg::*;
#(
    parameter int unsigned Q_W         = 16,
    parameter int unsigned R_W         = 8,
    parameter int unsigned ALPHA_SHIFT = 2,
    parameter int unsigned GAMMA_SHIFT = 1
) (
    input  logic signed [Q_W-1:0] q_old,
    input  logic signed [Q_W-1:0] q_max,
    input  logic signed [R_W-1:0] reward,
    output logic signed [Q_W-1:0] q_new_c
);
    localparam int unsigned TD_W = Q_W + 2;

    logic signed [TD_W-1:0] rew_x;
    logic signed [TD_W-1:0] qmax_x;
    logic signed [TD_W-1:0] qold_x;
    logic signed [TD_W-1:0] td;
    logic signed [TD_W-1:0] upd;

`ifdef QCTRL_SAT_EN
    localparam logic signed [TD_W-1:0] SAT_HI = TD_W'((64'sd1 <<< (Q_W - 1)) - 64'sd1);
    localparam logic signed [TD_W-1:0] SAT_LO = TD_W'(-(64'sd1 <<< (Q_W - 1)));
`else
    logic [TD_W-Q_W-1:0] upd_hi_unused;
`endif

    always_comb begin
        rew_x  = TD_W'(reward);
        qold_x = TD_W'(q_old);
        qmax_x = TD_W'(q_max) >>> GAMMA_SHIFT;
        td     = rew_x + qmax_x - qold_x;
        upd    = qold_x + (td >>> ALPHA_SHIFT);
`ifdef QCTRL_SAT_EN
        if (upd > SAT_HI) begin
            q_new_c = SAT_HI[Q_W-1:0];
        end else if (upd < SAT_LO) begin
            q_new_c = SAT_LO[Q_W-1:0];
        end else begin
            q_new_c = upd[Q_W-1:0];
        end
`else
        {upd_hi_unused, q_new_c} = upd;
`endif
    end

endmodule

// File: rtl/qlearn_step_ctrl.sv
// Q-learning episode sequencer: ACT -> RDQ -> RDMAX -> CALC -> WR per step.
// Optional macro QCTRL_SAT_EN makes the written Q value saturate instead of wrap.
module qlearn_step_ctrl
    import qlearn_pkg::*;
#(
    parameter int unsigned Q_W         = 16,
    parameter int unsigned R_W         = 8,
    parameter int unsigned ALPHA_SHIFT = 2,
    parameter int unsigned GAMMA_SHIFT = 1,
    parameter int unsigned MAX_STEPS   = 64,
    parameter int unsigned START_STATE = 1,
    parameter int unsigned GOAL_STATE  = 15
) (
    input  logic               clk,
    input  logic               rst,
    qlearn_step_ctrl_if.master bus
);
    localparam logic [STATE_W-1:0] START_SEL  = STATE_W'(START_STATE);
    localparam logic [STATE_W-1:0] GOAL_SEL   = STATE_W'(GOAL_STATE);
    localparam logic [8:0]         STEP_LIMIT = 9'(MAX_STEPS);

    ctrl_state_e state_q, state_d;

    logic [STATE_W-1:0]    cur_q, cur_d;
    logic [STATE_W-1:0]    nxt_q, nxt_d;
    logic [STATE_W-1:0]    at_q, at_d;
    logic [ACT_W-1:0]      act_q, act_d;
    logic signed [R_W-1:0] rew_q, rew_d;
    logic signed [Q_W-1:0] q_old_q, q_old_d;
    logic signed [Q_W-1:0] q_wdata_q, q_wdata_d;
    logic signed [Q_W-1:0] q_new_c;
    logic [7:0]            steps_q, steps_d;
    logic                  goal_q, goal_d;
    logic                  act_req_q, act_req_d;
    logic                  q_we_q, q_we_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [8:0] steps_inc_c;
    logic       nxt_goal_c;
    logic       last_step_c;

    qlearn_td_calc #(
        .Q_W         (Q_W),
        .R_W         (R_W),
        .ALPHA_SHIFT (ALPHA_SHIFT),
        .GAMMA_SHIFT (GAMMA_SHIFT)
    ) u_td_calc (
        .q_old   (q_old_q),
        .q_max   (bus.q_max_data),
        .reward  (rew_q),
        .q_new_c (q_new_c)
    );

    always_comb begin
        steps_inc_c = {1'b0, steps_q} + 9'd1;
        nxt_goal_c  = (nxt_q == GOAL_SEL);
        last_step_c = nxt_goal_c || (steps_inc_c >= STEP_LIMIT);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_ACT;
            ST_ACT:   if (bus.act_ack) state_d = ST_RDQ;
            ST_RDQ:   state_d = ST_RDMAX;
            ST_RDMAX: state_d = ST_CALC;
            ST_CALC:  state_d = ST_WR;
            ST_WR:    state_d = last_step_c ? ST_DONE : ST_ACT;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (bus.abort) begin
            state_d = ST_IDLE;
        end
    end

    // Output decode from the upcoming state so every output leaves a flop
    always_comb begin
        at_d      = SEL_NONE;
        act_req_d = 1'b0;
        q_we_d    = 1'b0;
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
        case (state_d)
            ST_ACT:   act_req_d = 1'b1;
            ST_RDQ:   at_d = cur_q;
            ST_RDMAX: at_d = nxt_q;
            ST_WR: begin
                at_d   = cur_q;
                q_we_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Episode datapath: action latch, Q capture, step bookkeeping
    always_comb begin
        cur_d     = cur_q;
        nxt_d     = nxt_q;
        act_d     = act_q;
        rew_d     = rew_q;
        q_old_d   = q_old_q;
        q_wdata_d = q_wdata_q;
        steps_d   = steps_q;
        goal_d    = goal_q;
        if (state_q == ST_IDLE && state_d == ST_ACT) begin
            cur_d   = START_SEL;
            steps_d = 8'd0;
            goal_d  = 1'b0;
        end
        if (state_q == ST_ACT && state_d == ST_RDQ) begin
            act_d = bus.act_dir;
            rew_d = bus.env_reward;
            nxt_d = (bus.env_next == SEL_NONE) ? cur_q : bus.env_next;
        end
        if (state_q == ST_RDMAX) begin
            q_old_d = bus.q_rd_data;
        end
        if (state_q == ST_CALC) begin
            q_wdata_d = q_new_c;
        end
        if (state_q == ST_WR) begin
            cur_d   = nxt_q;
            steps_d = (steps_inc_c >= STEP_LIMIT) ? STEP_LIMIT[7:0] : steps_inc_c[7:0];
            goal_d  = goal_q | nxt_goal_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_q     <= SEL_NONE;
            nxt_q     <= SEL_NONE;
            at_q      <= SEL_NONE;
            act_q     <= '0;
            rew_q     <= '0;
            q_old_q   <= '0;
            q_wdata_q <= '0;
            steps_q   <= 8'd0;
            goal_q    <= 1'b0;
            act_req_q <= 1'b0;
            q_we_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            cur_q     <= cur_d;
            nxt_q     <= nxt_d;
            at_q      <= at_d;
            act_q     <= act_d;
            rew_q     <= rew_d;
            q_old_q   <= q_old_d;
            q_wdata_q <= q_wdata_d;
            steps_q   <= steps_d;
            goal_q    <= goal_d;
            act_req_q <= act_req_d;
            q_we_q    <= q_we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.at           = at_q;
    assign bus.q_act        = act_q;
    assign bus.q_we         = q_we_q;
    assign bus.q_wdata      = q_wdata_q;
    assign bus.act_req      = act_req_q;
    assign bus.cur_state    = cur_q;
    assign bus.steps        = steps_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.goal_reached = goal_q;

endmodule

// File: tb/tb_qlearn_step_ctrl.sv
// Randomized episode bench for qlearn_step_ctrl with a behavioural Q-table and TD model.
module tb_qlearn_step_ctrl;
    import qlearn_pkg::*;

    localparam int unsigned Q_W   = 16;
    localparam int unsigned R_W   = 8;
    localparam int unsigned AS    = 2;
    localparam int unsigned GS    = 1;
    localparam int unsigned MAXS  = 4;
    localparam int unsigned START = 14;
    localparam int unsigned GOAL  = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    qlearn_step_ctrl_if #(.Q_W(Q_W), .R_W(R_W)) bus ();

    qlearn_step_ctrl #(
        .Q_W(Q_W), .R_W(R_W), .ALPHA_SHIFT(AS), .GAMMA_SHIFT(GS),
        .MAX_STEPS(MAXS), .START_STATE(START), .GOAL_STATE(GOAL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic signed [Q_W-1:0] qmem [16][4];
    logic [3:0] at_last   = 4'd0;
    logic [1:0] qact_last = 2'd0;
    int forced_rew;
    bit use_forced;

    task automatic check_val(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic signed [Q_W-1:0] row_max(input logic [3:0] s);
        logic signed [Q_W-1:0] m = qmem[s][0];
        for (int j = 1; j < 4; j++) if (qmem[s][j] > m) m = qmem[s][j];
        return m;
    endfunction

    function automatic longint floor_div2(input longint x, input int s);
        longint d = longint'(1) << s;
        if (x >= 0) return x / d;
        return -((-x + d - 1) / d);
    endfunction

    // Expected written Q value from the learning rule with plain integer arithmetic
    function automatic logic signed [Q_W-1:0] exp_q(input longint qo, input longint qm,
                                                    input longint r);
        longint td = r + floor_div2(qm, GS) - qo;
        longint u  = qo + floor_div2(td, AS);
        logic signed [Q_W-1:0] w;
`ifdef QCTRL_SAT_EN
        if (u > 32767) u = 32767;
        if (u < -32768) u = -32768;
`endif
        w = Q_W'(u);
        return w;
    endfunction

    // One clock; the Q bank answers for the select presented in the previous cycle
    task automatic tick();
        @(posedge clk);
        #1;
        bus.q_rd_data  = qmem[at_last][qact_last];
        bus.q_max_data = row_max(at_last);
        at_last   = bus.at;
        qact_last = bus.q_act;
    endtask

    task automatic check_after_abort();
        check_val("abort_busy", bus.busy, 0);
        check_val("abort_at", bus.at, 0);
        check_val("abort_done", bus.done, 0);
        check_val("abort_we", bus.q_we, 0);
        tick();
        check_val("abort_nodone", bus.done, 0);
        check_val("abort_idle", bus.busy, 0);
    endtask

    // mode: 0 random, 1 straight to goal, 2 wall walk, 3 never reaches goal
    task automatic run_episode(input int mode, input int ab_step, input int ab_phase);
        logic [3:0] cur, en, nxt;
        logic [1:0] dir;
        logic signed [7:0] rw;
        logic signed [Q_W-1:0] e;
        int steps;
        bit goal, fin;
        int s;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_val("st_busy", bus.busy, 1);
        check_val("st_req", bus.act_req, 1);
        check_val("st_cur", bus.cur_state, START);
        check_val("st_steps", bus.steps, 0);
        check_val("st_goal", bus.goal_reached, 0);
        cur = 4'(START); steps = 0; goal = 0; fin = 0; s = 0;
        while (!fin) begin
            repeat ($urandom_range(0, 2)) begin
                bus.start = 1'($urandom);
                tick();
                check_val("act_hold", bus.act_req, 1);
            end
            bus.start = 1'b0;
            dir = 2'($urandom);
            case (mode)
                1: en = 4'(GOAL);
                2: en = (s == 0) ? 4'd3 : (s == 1) ? 4'd0 : 4'(GOAL);
                3: en = 4'($urandom % 15);
                default: en = ($urandom % 4 == 0) ? 4'(GOAL) : 4'($urandom % 15);
            endcase
            rw = use_forced ? 8'(forced_rew) : 8'($urandom);
            bus.act_ack = 1'b1; bus.act_dir = dir; bus.env_next = en; bus.env_reward = rw;
            tick();
            bus.act_ack = 1'b0;
            bus.act_dir = 2'($urandom); bus.env_next = 4'($urandom); bus.env_reward = 8'($urandom);
            nxt = (en == 4'd0) ? cur : en;
            e = exp_q(longint'(qmem[cur][dir]), longint'(row_max(nxt)), longint'(rw));
            // RDQ
            check_val("rdq_at", bus.at, cur);
            check_val("rdq_act", bus.q_act, dir);
            check_val("rdq_req", bus.act_req, 0);
            bus.abort = (s == ab_step && ab_phase == 1);
            bus.start = 1'($urandom);
            tick();
            bus.start = 1'b0;
            if (bus.abort) begin bus.abort = 1'b0; check_after_abort(); return; end
            // RDMAX
            check_val("rdmax_at", bus.at, nxt);
            check_val("rdmax_we", bus.q_we, 0);
            bus.abort = (s == ab_step && ab_phase == 2);
            tick();
            if (bus.abort) begin bus.abort = 1'b0; check_after_abort(); return; end
            // CALC
            check_val("calc_we", bus.q_we, 0);
            bus.abort = (s == ab_step && ab_phase == 3);
            tick();
            if (bus.abort) begin bus.abort = 1'b0; check_after_abort(); return; end
            // WR
            check_val("wr_we", bus.q_we, 1);
            check_val("wr_at", bus.at, cur);
            check_val("wr_act", bus.q_act, dir);
            check_val("wr_data", bus.q_wdata, e);
            qmem[cur][dir] = e;
            steps++;
            cur  = nxt;
            goal = goal | (nxt == 4'(GOAL));
            fin  = (nxt == 4'(GOAL)) || (steps == int'(MAXS));
            bus.abort = (s == ab_step && ab_phase == 4);
            tick();
            if (bus.abort) begin bus.abort = 1'b0; check_after_abort(); return; end
            if (fin) begin
                check_val("done_pulse", bus.done, 1);
                check_val("done_at", bus.at, 0);
                check_val("done_goal", bus.goal_reached, goal);
                check_val("done_steps", bus.steps, steps);
                check_val("done_cur", bus.cur_state, cur);
                bus.start = 1'($urandom);
                tick();
                bus.start = 1'b0;
                check_val("end_done", bus.done, 0);
                check_val("end_busy", bus.busy, 0);
                check_val("end_req", bus.act_req, 0);
                check_val("end_goal", bus.goal_reached, goal);
            end else begin
                check_val("next_req", bus.act_req, 1);
                check_val("next_cur", bus.cur_state, cur);
                check_val("next_steps", bus.steps, steps);
                check_val("next_goal", bus.goal_reached, 0);
                check_val("next_done", bus.done, 0);
            end
            s++;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.act_ack = 1'b0; bus.act_dir = 2'd0;
        bus.env_next = 4'd0; bus.env_reward = 8'sd0;
        bus.q_rd_data = '0; bus.q_max_data = '0;
        use_forced = 1'b0; forced_rew = 0;
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 4; j++) qmem[i][j] = Q_W'($urandom);
        #2;
        check_val("rst_at", bus.at, 0);
        check_val("rst_qact", bus.q_act, 0);
        check_val("rst_we", bus.q_we, 0);
        check_val("rst_wdata", bus.q_wdata, 0);
        check_val("rst_req", bus.act_req, 0);
        check_val("rst_cur", bus.cur_state, 0);
        check_val("rst_steps", bus.steps, 0);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_done", bus.done, 0);
        check_val("rst_goal", bus.goal_reached, 0);
        @(negedge clk); rst = 1'b0;
        tick();
        check_val("idle_busy", bus.busy, 0);

        // Goal in one step from zeroed Q rows: expect 25 written
        for (int j = 0; j < 4; j++) begin qmem[14][j] = '0; qmem[15][j] = '0; end
        use_forced = 1'b1; forced_rew = 100;
        run_episode(1, -1, 0);
        check_val("goal_q_value", qmem[14][qact_last], 25);
        // Large operands near the top of range
        for (int j = 0; j < 4; j++) begin qmem[14][j] = 16'sd32760; qmem[15][j] = 16'sd32767; end
        forced_rew = 127;
        run_episode(1, -1, 0);
        use_forced = 1'b0;

        run_episode(2, -1, 0);
        run_episode(3, -1, 0);
        run_episode(0, 0, 2);
        run_episode(3, 1, 4);

        // Asynchronous reset while waiting for the action ack
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_val("pre_rst_req", bus.act_req, 1);
        #3 rst = 1'b1;
        #1;
        check_val("arst_req", bus.act_req, 0);
        check_val("arst_busy", bus.busy, 0);
        check_val("arst_cur", bus.cur_state, 0);
        check_val("arst_steps", bus.steps, 0);
        check_val("arst_at", bus.at, 0);
        check_val("arst_qact", bus.q_act, 0);
        check_val("arst_wdata", bus.q_wdata, 0);
        @(negedge clk); rst = 1'b0;
        at_last = 4'd0; qact_last = 2'd0;
        tick();
        check_val("post_rst_idle", bus.busy, 0);

        for (int k = 0; k < 40; k++) begin
            if ($urandom % 5 == 0)
                run_episode(0, int'($urandom_range(0, 3)), int'($urandom_range(1, 4)));
            else
                run_episode(int'($urandom_range(0, 3)), -1, 0);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
